pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready flow control, synchronous flush and bubble gating of control bits. It generalises the fixed EXE/MEM latch and can be used between any two CPU stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries an instruction word, a data payload of configurable width and a control vector of configurable width. An optional skid buffer, enabled at compile time, removes the combinational ready path.

---
 rtl/pipe_stage_reg_if.sv | 69 ++++++
 rtl/pipe_stage_reg.sv | 195 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Purpose: bundles the upstream/downstream handshake, payload, flush and stall counter of one pipe_stage_reg.
// Latency: none (wires only); the stage behind the slave modport adds one register cycle.
// Backpressure: in_ready/out_ready carry valid-ready flow control in each direction.
//
// Signals (stage-centric direction, as seen through the slave modport):
//   in_valid  in   upstream beat present
//   in_ready  out  stage can accept a beat this cycle
//   in_inst   in   instruction word (32)
//   in_data   in   payload (DATA_W)
//   in_ctrl   in   control vector (CTRL_W)
//   flush     in   kill stage contents and the incoming beat
//   out_valid out  downstream beat present
//   out_ready in   downstream accepts
//   out_inst  out  registered instruction (32)
//   out_data  out  registered payload (DATA_W)
//   out_ctrl  out  registered control, zero whenever out_valid=0
//   stall_cnt out  saturating count of stalled output cycles (CNT_W)
// The slave modport is taken by the stage; the master modport by whatever drives it.

interface pipe_stage_reg_if #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 5,
   parameter int CNT_W  = 16
);

   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_inst;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [CNT_W-1:0]  stall_cnt;

   modport slave (
      input  in_valid,
      input  in_inst,
      input  in_data,
      input  in_ctrl,
      input  flush,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_inst,
      output out_data,
      output out_ctrl,
      output stall_cnt
   );

   modport master (
      output in_valid,
      output in_inst,
      output in_data,
      output in_ctrl,
      output flush,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_inst,
      input  out_data,
      input  out_ctrl,
      input  stall_cnt
   );

endinterface

// File: rtl/pipe_stage_reg.sv
// Purpose: generic CPU pipeline stage register (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with flush and bubble gating.
// Latency: 1 cycle from accepted beat to out_valid; 1 beat/cycle throughput with out_ready held high.
// Backpressure: combinational in_ready by default; with PIPE_STAGE_SKID_EN a 2-deep skid makes in_ready registered.
//
// Ports:
//   clk       in   clock, all state on the rising edge
//   rst       in   asynchronous reset, active-low
//   io_stage  pipe_stage_reg_if.slave: in_valid/in_ready/in_inst/in_data/in_ctrl, flush,
//             out_valid/out_ready/out_inst/out_data/out_ctrl, stall_cnt
// Compile-time option:
//   PIPE_STAGE_SKID_EN  when defined, adds one skid entry behind the main register so in_ready
//                       no longer depends combinationally on out_ready.

module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 5,
   parameter int CNT_W  = 16
) (
   input logic             clk,
   input logic             rst,
   pipe_stage_reg_if.slave io_stage
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [31:0]      NOP     = 32'h0000_0000;

   // ------------------------------------------------------------------
   // Main register (the one that drives the downstream stage)
   // ------------------------------------------------------------------
   logic              r_out_valid;
   logic [31:0]       r_inst;
   logic [DATA_W-1:0] r_data;
   logic [CTRL_W-1:0] r_ctrl;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_out_valid_nxt;
   logic [31:0]       w_inst_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic [CTRL_W-1:0] w_ctrl_nxt;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_consume;
   logic              w_stall;

`ifdef PIPE_STAGE_SKID_EN
   // ------------------------------------------------------------------
   // Skid entry: absorbs the one beat that may arrive while the main
   // register is stalled, because in_ready is only told about it a cycle
   // later.
   // ------------------------------------------------------------------
   logic              r_skid_valid;
   logic [31:0]       r_skid_inst;
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic              r_in_ready;

   logic              w_skid_valid_nxt;
   logic              w_skid_load;

   // Registered ready: low in reset, rises on the first edge after release,
   // and afterwards mirrors the emptiness of the skid entry.
   assign w_in_ready = r_in_ready;
`else
   // Single-entry stage: take a beat when empty or when the held beat is
   // leaving this cycle. Forced low while reset is asserted.
   assign w_in_ready = rst & (~r_out_valid | io_stage.out_ready);
`endif

   // A beat presented together with flush is dropped, even with in_ready high.
   assign w_accept  = io_stage.in_valid & w_in_ready & ~io_stage.flush;
   assign w_consume = r_out_valid & io_stage.out_ready;
   assign w_stall   = r_out_valid & ~io_stage.out_ready;

   // ------------------------------------------------------------------
   // Next-state selection
   // ------------------------------------------------------------------
   always_comb begin
      w_out_valid_nxt = r_out_valid;
      w_inst_nxt      = r_inst;
      w_data_nxt      = r_data;
      w_ctrl_nxt      = r_ctrl;
`ifdef PIPE_STAGE_SKID_EN
      w_skid_valid_nxt = r_skid_valid;
      w_skid_load      = 1'b0;
`endif

      if (io_stage.flush) begin
         // A consume in this cycle still completes downstream; the stage
         // simply ends up empty. Data and ctrl are left alone: out_ctrl is
         // gated by out_valid, so stale ctrl can never leak.
         w_out_valid_nxt = 1'b0;
         w_inst_nxt      = NOP;
`ifdef PIPE_STAGE_SKID_EN
         w_skid_valid_nxt = 1'b0;
`endif
      end else begin
`ifdef PIPE_STAGE_SKID_EN
         if (!r_out_valid || w_consume) begin
            // Main register is free at this edge. The skid entry is older
            // than any incoming beat, so it refills the main register first.
            if (r_skid_valid) begin
               w_out_valid_nxt  = 1'b1;
               w_inst_nxt       = r_skid_inst;
               w_data_nxt       = r_skid_data;
               w_ctrl_nxt       = r_skid_ctrl;
               w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
               w_out_valid_nxt = 1'b1;
               w_inst_nxt      = io_stage.in_inst;
               w_data_nxt      = io_stage.in_data;
               w_ctrl_nxt      = io_stage.in_ctrl;
            end else begin
               w_out_valid_nxt = 1'b0;
            end
         end else if (w_accept) begin
            // Main register held by a stall: park the beat in the skid.
            w_skid_load      = 1'b1;
            w_skid_valid_nxt = 1'b1;
         end
`else
         // An accept while full implies a consume in the same cycle, so the
         // new beat simply replaces the departing one.
         if (w_accept) begin
            w_out_valid_nxt = 1'b1;
            w_inst_nxt      = io_stage.in_inst;
            w_data_nxt      = io_stage.in_data;
            w_ctrl_nxt      = io_stage.in_ctrl;
         end else if (w_consume) begin
            w_out_valid_nxt = 1'b0;
         end
`endif
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_inst      <= '0;
         r_data      <= '0;
         r_ctrl      <= '0;
      end else begin
         r_out_valid <= w_out_valid_nxt;
         r_inst      <= w_inst_nxt;
         r_data      <= w_data_nxt;
         r_ctrl      <= w_ctrl_nxt;
      end
   end

`ifdef PIPE_STAGE_SKID_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_skid_valid <= 1'b0;
         r_skid_inst  <= '0;
         r_skid_data  <= '0;
         r_skid_ctrl  <= '0;
         r_in_ready   <= 1'b0;
      end else begin
         r_skid_valid <= w_skid_valid_nxt;
         r_in_ready   <= ~w_skid_valid_nxt;
         if (w_skid_load) begin
            r_skid_inst <= io_stage.in_inst;
            r_skid_data <= io_stage.in_data;
            r_skid_ctrl <= io_stage.in_ctrl;
         end
      end
   end
`endif

   // Stall counter: counts stalled output cycles, flush does not touch it,
   // and it sticks at all-ones until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign io_stage.in_ready  = w_in_ready;
   assign io_stage.out_valid = r_out_valid;
   assign io_stage.out_inst  = r_inst;
   assign io_stage.out_data  = r_data;
   // Bubble gating: an empty stage can never assert RegWrite/MemWrite.
   assign io_stage.out_ctrl  = r_ctrl & {CTRL_W{r_out_valid}};
   assign io_stage.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose: self-checking bench for pipe_stage_reg (either build) using a vector table,
// hand-written stall/flush/saturation/async-reset sequences and a beat scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_pipe_stage_reg;

   localparam int DATA_W = 64;
   localparam int CTRL_W = 5;
   localparam int CNT_W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .io_stage (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [31:0]       inst;
      logic [DATA_W-1:0] data;
      logic [CTRL_W-1:0] ctrl;
   } beat_t;

   beat_t sb[$];

   always @(negedge clk) begin
      beat_t e;
      if (!rst) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_unexpected: got inst %0h, expected no beat", bus.out_inst);
            end else begin
               e = sb.pop_front();
               chk("sb_inst", {32'h0, bus.out_inst}, {32'h0, e.inst});
               chk("sb_data", bus.out_data, e.data);
               chk("sb_ctrl", {59'h0, bus.out_ctrl}, {59'h0, e.ctrl});
            end
         end
         if (bus.flush)
            sb.delete();
         else if (bus.in_valid && bus.in_ready)
            sb.push_back('{inst: bus.in_inst, data: bus.in_data, ctrl: bus.in_ctrl});
      end
   end

   // ---------------- helpers ----------------
   task automatic drv(input logic v, input logic [31:0] inst, input logic [CTRL_W-1:0] c,
                      input logic f, input logic r);
      bus.in_valid  = v;
      bus.in_inst   = inst;
      bus.in_data   = {~inst, inst};
      bus.in_ctrl   = c;
      bus.flush     = f;
      bus.out_ready = r;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic ov, input logic [31:0] inst,
                          input logic [CTRL_W-1:0] c);
      chk({tag, "_ovld"}, {63'h0, bus.out_valid}, {63'h0, ov});
      chk({tag, "_inst"}, {32'h0, bus.out_inst}, {32'h0, inst});
      chk({tag, "_ctrl"}, {59'h0, bus.out_ctrl}, {59'h0, c});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic              vld;
      logic [31:0]       inst;
      logic [CTRL_W-1:0] ctrl;
      logic              fl;
      logic              ordy;
      logic              e_ovld;
      logic [31:0]       e_inst;
      logic [CTRL_W-1:0] e_ctrl;
      logic              e_irdy;
   } vec_t;

   vec_t vt[20];
   int   nv = 0;

   task automatic add(input logic v, input logic [31:0] inst, input logic [CTRL_W-1:0] c,
                      input logic f, input logic r, input logic eov, input logic [31:0] ei,
                      input logic [CTRL_W-1:0] ec, input logic eir);
      vt[nv] = '{vld: v, inst: inst, ctrl: c, fl: f, ordy: r,
                 e_ovld: eov, e_inst: ei, e_ctrl: ec, e_irdy: eir};
      nv++;
   endtask

   localparam logic [31:0] A = 32'h0000_0031;
   localparam logic [31:0] B = 32'h0000_0032;

   initial begin
      // Expected outputs are the state seen during the cycle the inputs are applied.
      // Streaming 8 beats with out_ready=1; ctrl = {1, inst[3:0]}.
      add(1, 32'h1, 5'h11, 0, 1,  0, 32'h0, 5'h00, 1);
      add(1, 32'h2, 5'h12, 0, 1,  1, 32'h1, 5'h11, 1);
      add(1, 32'h3, 5'h13, 0, 1,  1, 32'h2, 5'h12, 1);
      add(1, 32'h4, 5'h14, 0, 1,  1, 32'h3, 5'h13, 1);
      add(1, 32'h5, 5'h15, 0, 1,  1, 32'h4, 5'h14, 1);
      add(1, 32'h6, 5'h16, 0, 1,  1, 32'h5, 5'h15, 1);
      add(1, 32'h7, 5'h17, 0, 1,  1, 32'h6, 5'h16, 1);
      add(1, 32'h8, 5'h18, 0, 1,  1, 32'h7, 5'h17, 1);
      // Bubbles with all-ones ctrl: out_ctrl must stay 0, out_inst holds.
      add(0, 32'hAAAA, 5'h1F, 0, 1,  1, 32'h8, 5'h18, 1);
      add(0, 32'hBBBB, 5'h1F, 0, 1,  0, 32'h8, 5'h00, 1);
      add(0, 32'hCCCC, 5'h1F, 0, 1,  0, 32'h8, 5'h00, 1);
      // Fill, then flush with consume and a dropped all-ones beat.
      add(1, 32'h11, 5'h15, 0, 0,  0, 32'h8, 5'h00, 1);
      add(1, 32'hDEAD, 5'h1F, 1, 1,  1, 32'h11, 5'h15, 1);
      add(0, 32'h0, 5'h1F, 0, 1,  0, 32'h0, 5'h00, 1);
      // Normal beat after flush.
      add(1, 32'h21, 5'h03, 0, 1,  0, 32'h0, 5'h00, 1);
      add(0, 32'h0, 5'h1F, 0, 1,  1, 32'h21, 5'h03, 1);
      add(0, 32'h0, 5'h1F, 0, 1,  0, 32'h21, 5'h00, 1);

      // ---------------- reset ----------------
      drv(1, 32'h1234_5678, 5'h1F, 0, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_out("rst", 0, 32'h0, 5'h00);
      chk("rst_data", bus.out_data, 64'h0);
      chk("rst_cnt", {60'h0, bus.stall_cnt}, 64'h0);
      chk("rst_irdy", {63'h0, bus.in_ready}, 64'h0);
      nxt();
      rst = 1'b1;
      drv(0, 32'h0, 5'h1F, 0, 1);
      nxt();
      chk("rel_irdy", {63'h0, bus.in_ready}, 64'h1);
      chk_out("rel", 0, 32'h0, 5'h00);

      // ---------------- table ----------------
      for (int i = 0; i < nv; i++) begin
         drv(vt[i].vld, vt[i].inst, vt[i].ctrl, vt[i].fl, vt[i].ordy);
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), vt[i].e_ovld, vt[i].e_inst, vt[i].e_ctrl);
         chk($sformatf("vec%0d_irdy", i), {63'h0, bus.in_ready}, {63'h0, vt[i].e_irdy});
         nxt();
      end
      chk("tbl_cnt", {60'h0, bus.stall_cnt}, 64'h0);

      // ---------------- stall hold ----------------
      drv(1, A, 5'h0A, 0, 0);
      @(negedge clk);
      nxt();
      drv(1, B, 5'h0B, 0, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk_out("stall", 1, A, 5'h0A);
         chk("stall_data", bus.out_data, {~A, A});
         chk("stall_cnt", {60'h0, bus.stall_cnt}, 64'(k));
`ifdef PIPE_STAGE_SKID_EN
         chk("stall_irdy", {63'h0, bus.in_ready}, {63'h0, (k == 0)});
`else
         chk("stall_irdy", {63'h0, bus.in_ready}, 64'h0);
`endif
         nxt();
`ifdef PIPE_STAGE_SKID_EN
         if (k == 0) bus.in_valid = 1'b0;
`endif
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("stall_cnt5", {60'h0, bus.stall_cnt}, 64'd5);
      chk_out("rel_a", 1, A, 5'h0A);
      nxt();
      drv(0, 32'h0, 5'h1F, 0, 1);
      @(negedge clk);
      chk_out("rel_b", 1, B, 5'h0B);
      chk("rel_b_irdy", {63'h0, bus.in_ready}, 64'h1);
      chk("rel_b_cnt", {60'h0, bus.stall_cnt}, 64'd5);
      nxt();
      @(negedge clk);
      chk_out("drained", 0, B, 5'h00);
      nxt();

      // ---------------- flush while stalled ----------------
      drv(1, 32'h41, 5'h01, 0, 0);
      nxt();
      drv(1, 32'h42, 5'h02, 0, 0);
      nxt();
      drv(1, 32'h43, 5'h1F, 1, 0);
      @(negedge clk);
      chk_out("pre_fl", 1, 32'h41, 5'h01);
      nxt();
      drv(0, 32'h0, 5'h1F, 0, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_out("flush", 0, 32'h0, 5'h00);
         nxt();
      end
      chk("flush_irdy", {63'h0, bus.in_ready}, 64'h1);
      chk("flush_cnt", {60'h0, bus.stall_cnt}, 64'd7);

      // ---------------- saturation + async reset ----------------
      drv(1, 32'h51, 5'h05, 0, 0);
      nxt();
      drv(0, 32'h0, 5'h1F, 0, 0);
      repeat (20) nxt();
      @(negedge clk);
      chk("sat_cnt", {60'h0, bus.stall_cnt}, 64'hF);
      chk_out("sat", 1, 32'h51, 5'h05);
      @(posedge clk);
      #3;
      drv(1, 32'h99, 5'h1F, 0, 0);
      rst = 1'b0;
      #1;
      chk_out("arst", 0, 32'h0, 5'h00);
      chk("arst_cnt", {60'h0, bus.stall_cnt}, 64'h0);
      chk("arst_data", bus.out_data, 64'h0);
      chk("arst_irdy", {63'h0, bus.in_ready}, 64'h0);
      nxt();
      nxt();
      rst = 1'b1;
      drv(0, 32'h0, 5'h1F, 0, 1);
      nxt();
      chk("arst_rel_irdy", {63'h0, bus.in_ready}, 64'h1);
      chk_out("arst_rel", 0, 32'h0, 5'h00);

      // ---------------- one beat after reset ----------------
      drv(1, 32'h61, 5'h03, 0, 1);
      nxt();
      drv(0, 32'h0, 5'h1F, 0, 1);
      @(negedge clk);
      chk_out("post", 1, 32'h61, 5'h03);
      nxt();
      @(negedge clk);
      chk("sb_drain", 64'(sb.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
